// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit_serializer block.
// Optional parity support is selected with the BIT_SERIALIZER_PARITY_EN macro.
package bit_serializer_pkg;

    // Default parallel word width
    localparam int DEFAULT_WIDTH = 8;

    // Frame sequencer states; PARITY is only reachable with parity enabled
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Bit counter width able to hold 0..w
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Even parity of a zero-extended data word
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage : bit_serializer_pkg

// File: rtl/bit_serializer_if.sv
// Handshake and serial-stream bundle for bit_serializer.
// slave: the serializer itself; master: the word source / stream observer.
interface bit_serializer_if
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  dout,
        input  dout_valid,
        input  frame_start,
        input  frame_end,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output dout,
        output dout_valid,
        output frame_start,
        output frame_end,
        output busy
    );

endinterface : bit_serializer_if

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word over valid/ready
// and emits it one bit per clock with frame_start/frame_end strobes.
// Back-to-back words are accepted on the final cycle of a frame.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    bit_serializer_if.slave  bus
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
`ifndef BIT_SERIALIZER_PARITY_EN
    localparam logic [CW-1:0]  CNT_PEN  = CW'(WIDTH - 2);
`endif

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic             dout_r;
    logic             dout_valid_r;
    logic             frame_start_r;
    logic             frame_end_r;
    logic             busy_r;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             parity_r;
`endif
    logic             in_ready_s;
    logic             accept_s;

    // Ready when idle or on the final cycle of a frame, never during reset
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    in_ready_s = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
                SHIFT:   in_ready_s = 1'b0;
                PARITY:  in_ready_s = 1'b1;
`else
                SHIFT:   in_ready_s = (cnt_r == CNT_LAST);
`endif
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s = bus.in_valid & in_ready_s;

    // Frame sequencer: loads words, shifts bits out and drives registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= CNT_ZERO;
            shift_r       <= {WIDTH{1'b0}};
            dout_r        <= 1'b0;
            dout_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_end_r   <= 1'b0;
            busy_r        <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_r      <= 1'b0;
`endif
        end else if (accept_s) begin
            // First bit goes out directly; the rest wait in shift_r
            state_r       <= SHIFT;
            cnt_r         <= CNT_ZERO;
            if (MSB_FIRST) begin
                dout_r    <= bus.in_data[WIDTH-1];
                shift_r   <= {bus.in_data[WIDTH-2:0], 1'b0};
            end else begin
                dout_r    <= bus.in_data[0];
                shift_r   <= {1'b0, bus.in_data[WIDTH-1:1]};
            end
            dout_valid_r  <= 1'b1;
            frame_start_r <= 1'b1;
            frame_end_r   <= 1'b0;
            busy_r        <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_r      <= even_parity(32'(bus.in_data));
`endif
        end else begin
            case (state_r)
                SHIFT: begin
                    if (cnt_r == CNT_LAST) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        state_r       <= PARITY;
                        dout_r        <= parity_r;
                        dout_valid_r  <= 1'b1;
                        frame_start_r <= 1'b0;
                        frame_end_r   <= 1'b1;
                        busy_r        <= 1'b1;
`else
                        state_r       <= IDLE;
                        cnt_r         <= CNT_ZERO;
                        dout_r        <= 1'b0;
                        dout_valid_r  <= 1'b0;
                        frame_start_r <= 1'b0;
                        frame_end_r   <= 1'b0;
                        busy_r        <= 1'b0;
`endif
                    end else begin
                        cnt_r         <= cnt_r + CNT_ONE;
                        if (MSB_FIRST) begin
                            dout_r    <= shift_r[WIDTH-1];
                            shift_r   <= {shift_r[WIDTH-2:0], 1'b0};
                        end else begin
                            dout_r    <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[WIDTH-1:1]};
                        end
                        dout_valid_r  <= 1'b1;
                        frame_start_r <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
                        frame_end_r   <= 1'b0;
`else
                        frame_end_r   <= (cnt_r == CNT_PEN);
`endif
                        busy_r        <= 1'b1;
                    end
                end
                default: begin
                    // IDLE, or end of the parity cycle with no new word
                    state_r       <= IDLE;
                    cnt_r         <= CNT_ZERO;
                    dout_r        <= 1'b0;
                    dout_valid_r  <= 1'b0;
                    frame_start_r <= 1'b0;
                    frame_end_r   <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.dout        = dout_r;
    assign bus.dout_valid  = dout_valid_r;
    assign bus.frame_start = frame_start_r;
    assign bus.frame_end   = frame_end_r;
    assign bus.busy        = busy_r;

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: an MSB-first and an LSB-first
// instance receive identical handshake traffic; a queue-of-expected-bits
// model predicts every output. Honours BIT_SERIALIZER_PARITY_EN.
module tb_bit_serializer;
    import bit_serializer_pkg::*;

    localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(W)) bus_m ();
    bit_serializer_if #(.WIDTH(W)) bus_l ();

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    int n_vec = 0;
    int n_err = 0;

    // Bits still to appear on dout for each instance; head = bit on dout now
    bit exp_m[$];
    bit exp_l[$];
    // Words waiting to be accepted by the serializers
    logic [W-1:0] tx_q[$];

    // Compare one observed value against its expectation
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Append the bits of one frame to both expected streams
    function automatic void push_frame(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            exp_m.push_back(w[W-1-i]);
            exp_l.push_back(w[i]);
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        exp_m.push_back(^w);
        exp_l.push_back(^w);
`endif
    endfunction

    // Check registered outputs of both instances against the model
    task automatic check_outputs();
        logic e_dm, e_dl, e_v, e_fs, e_fe;
        e_dm = 1'b0; e_dl = 1'b0; e_v = 1'b0; e_fs = 1'b0; e_fe = 1'b0;
        if (exp_m.size() > 0) begin
            e_dm = exp_m[0];
            e_dl = exp_l[0];
            e_v  = 1'b1;
            e_fs = (exp_m.size() == FLEN);
            e_fe = (exp_m.size() == 1);
        end
        check_eq("msb.dout",        32'(bus_m.dout),        32'(e_dm));
        check_eq("msb.dout_valid",  32'(bus_m.dout_valid),  32'(e_v));
        check_eq("msb.frame_start", 32'(bus_m.frame_start), 32'(e_fs));
        check_eq("msb.frame_end",   32'(bus_m.frame_end),   32'(e_fe));
        check_eq("msb.busy",        32'(bus_m.busy),        32'(e_v));
        check_eq("lsb.dout",        32'(bus_l.dout),        32'(e_dl));
        check_eq("lsb.dout_valid",  32'(bus_l.dout_valid),  32'(e_v));
        check_eq("lsb.frame_start", 32'(bus_l.frame_start), 32'(e_fs));
        check_eq("lsb.frame_end",   32'(bus_l.frame_end),   32'(e_fe));
        check_eq("lsb.busy",        32'(bus_l.busy),        32'(e_v));
    endtask

    // One clock cycle: drive inputs after negedge, check ready, advance model
    task automatic drive_cycle(input logic r, input int gap_pct);
        logic         v;
        logic         rdy_exp;
        logic         acc;
        logic [W-1:0] d;
        v = 1'b0;
        d = W'($urandom);
        if (tx_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            v = 1'b1;
            d = tx_q[0];
        end
        rst            = r;
        bus_m.in_valid = v;
        bus_m.in_data  = d;
        bus_l.in_valid = v;
        bus_l.in_data  = d;
        #1;
        rdy_exp = !r && (exp_m.size() <= 1);
        check_eq("msb.in_ready", 32'(bus_m.in_ready), 32'(rdy_exp));
        check_eq("lsb.in_ready", 32'(bus_l.in_ready), 32'(rdy_exp));
        acc = v && rdy_exp;
        @(posedge clk);
        if (r) begin
            exp_m.delete();
            exp_l.delete();
        end else begin
            if (exp_m.size() > 0) begin
                void'(exp_m.pop_front());
                void'(exp_l.pop_front());
            end
            if (acc) begin
                push_frame(d);
                void'(tx_q.pop_front());
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    // Directed scenarios followed by randomized traffic with sporadic resets
    initial begin
        bus_m.in_valid = 1'b0;
        bus_m.in_data  = {W{1'b0}};
        bus_l.in_valid = 1'b0;
        bus_l.in_data  = {W{1'b0}};
        @(negedge clk);
        repeat (3) drive_cycle(1'b1, 0);

        // Single word
        tx_q.push_back(8'hA5);
        repeat (FLEN + 3) drive_cycle(1'b0, 0);

        // Back-to-back words with valid held high
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h3C);
        repeat (2 * FLEN + 3) drive_cycle(1'b0, 0);

        // Second word held while first frame is in flight
        tx_q.push_back(8'h01);
        tx_q.push_back(8'hFF);
        repeat (2 * FLEN + 3) drive_cycle(1'b0, 0);

        // Reset during cycle 4 of a frame, then a clean frame
        tx_q.push_back(8'hFF);
        repeat (4) drive_cycle(1'b0, 0);
        drive_cycle(1'b1, 0);
        tx_q.push_back(8'h81);
        repeat (FLEN + 3) drive_cycle(1'b0, 0);

        // Parity-sensitive words
        tx_q.push_back(8'h07);
        tx_q.push_back(8'hA5);
        repeat (2 * FLEN + 3) drive_cycle(1'b0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (tx_q.size() == 0 && $urandom_range(3) != 0) begin
                tx_q.push_back(W'($urandom));
            end
            drive_cycle(($urandom_range(63) == 0), 30);
        end
        tx_q.delete();
        repeat (FLEN + 2) drive_cycle(1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bit_serializer
